// File: rtl/mul_div_unit.sv
`timescale 1ns/1ps
// mul_div_unit: multi-cycle mult/div engine that owns the HI/LO pair.
// Results are computed at acceptance and released after a fixed latency.
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES - 1);

    logic          r_busy;
    logic          r_skip;
    logic [CW-1:0] r_count;
    logic [63:0]   r_pend;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;

    logic [63:0] w_ext_as;
    logic [63:0] w_ext_bs;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_dvs_s;
    logic [31:0] w_dvs_u;
    logic [31:0] w_qm_s;
    logic [31:0] w_rm_s;
    logic [31:0] w_q_s;
    logic [31:0] w_r_s;
    logic [31:0] w_q_u;
    logic [31:0] w_r_u;
    logic        w_b_zero;
    logic [63:0] w_pend;

    assign w_ext_as = {{32{SrcA[31]}}, SrcA};
    assign w_ext_bs = {{32{SrcB[31]}}, SrcB};
    assign w_prod_s = w_ext_as * w_ext_bs;
    assign w_prod_u = {32'd0, SrcA} * {32'd0, SrcB};

    // Signed divide on magnitudes so 0x80000000 / -1 wraps cleanly.
    assign w_neg_a  = SrcA[31];
    assign w_neg_b  = SrcB[31];
    assign w_mag_a  = w_neg_a ? (~SrcA + 32'd1) : SrcA;
    assign w_mag_b  = w_neg_b ? (~SrcB + 32'd1) : SrcB;
    assign w_b_zero = (SrcB == 32'd0);
    assign w_dvs_s  = w_b_zero ? 32'd1 : w_mag_b;
    assign w_dvs_u  = w_b_zero ? 32'd1 : SrcB;
    assign w_qm_s   = w_mag_a / w_dvs_s;
    assign w_rm_s   = w_mag_a % w_dvs_s;
    assign w_q_s    = (w_neg_a ^ w_neg_b) ? (~w_qm_s + 32'd1) : w_qm_s;
    assign w_r_s    = w_neg_a ? (~w_rm_s + 32'd1) : w_rm_s;
    assign w_q_u    = SrcA / w_dvs_u;
    assign w_r_u    = SrcA % w_dvs_u;

    always_comb begin
        w_pend = w_prod_s;
        case (MDOp[1:0])
            2'd0:    w_pend = w_prod_s;
            2'd1:    w_pend = w_prod_u;
            2'd2:    w_pend = {w_r_s, w_q_s};
            default: w_pend = {w_r_u, w_q_u};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy  <= 1'b0;
            r_skip  <= 1'b0;
            r_count <= '0;
            r_pend  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (r_busy) begin
            if (r_count == '0) begin
                r_busy <= 1'b0;
                if (!r_skip) begin
                    r_hi <= r_pend[63:32];
                    r_lo <= r_pend[31:0];
                end
            end else begin
                r_count <= r_count - 1'b1;
            end
        end else if (Start) begin
            case (MDOp)
                3'd0, 3'd1: begin
                    r_pend  <= w_pend;
                    r_skip  <= 1'b0;
                    r_count <= MULT_LD;
                    r_busy  <= 1'b1;
                end
                3'd2, 3'd3: begin
                    r_pend  <= w_pend;
                    r_skip  <= w_b_zero;
                    r_count <= DIV_LD;
                    r_busy  <= 1'b1;
                end
                3'd4:    r_hi <= SrcA;
                3'd5:    r_lo <= SrcA;
                default: ;
            endcase
        end
    end

    assign Busy = r_busy;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
`timescale 1ns/1ps
// tb_mul_div_unit: directed scoreboard bench for the HI/LO mult/div unit.
// Expected results are queued at issue and checked when Busy drops.
module tb_mul_div_unit;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    res_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MDOp  (MDOp),
        .SrcA  (SrcA),
        .SrcB  (SrcB),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] hi, input logic [31:0] lo);
        res_t r;
        r.hi = hi;
        r.lo = lo;
        sb.push_back(r);
    endtask

    // Drives one Start pulse; called and returns at a falling edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        Start = 1'b1;
        MDOp  = op;
        SrcA  = a;
        SrcB  = b;
        @(negedge clk);
        Start = 1'b0;
        MDOp  = 3'd6;
        SrcA  = $urandom;
        SrcB  = $urandom;
    endtask

    task automatic finish_long(input string tag, input int n, input int inj,
                               input logic hold);
        int   cnt;
        res_t r;
        cnt = 0;
        while (Busy === 1'b1 && cnt < 200) begin
            cnt++;
            if (hold) begin
                Start = 1'b1;
                MDOp  = 3'd0;
                SrcA  = 32'd3;
                SrcB  = 32'd4;
            end else if (cnt == inj) begin
                Start = 1'b1;
                MDOp  = 3'd5;
                SrcA  = 32'h55;
                $display("protocol warning: Start while Busy (%s)", tag);
            end else begin
                Start = 1'b0;
                SrcA  = $urandom;
                SrcB  = $urandom;
            end
            @(negedge clk);
        end
        chk({tag, "/busy_cycles"}, cnt, n);
        chk({tag, "/busy_low"}, {31'd0, Busy}, 32'd0);
        chk({tag, "/sb_size"}, sb.size(), 32'd1);
        if (sb.size() > 0) begin
            r = sb.pop_front();
            chk({tag, "/HI"}, HI, r.hi);
            chk({tag, "/LO"}, LO, r.lo);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        Start = 1'b0;
        MDOp  = 3'd0;
        SrcA  = '0;
        SrcB  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset/HI", HI, 32'd0);
        chk("reset/LO", LO, 32'd0);
        chk("reset/busy", {31'd0, Busy}, 32'd0);

        issue(3'd4, 32'h12345678, 32'd0);
        chk("mthi/HI", HI, 32'h12345678);
        chk("mthi/LO", LO, 32'd0);
        chk("mthi/busy", {31'd0, Busy}, 32'd0);

        issue(3'd6, 32'hDEADBEEF, 32'd1);
        chk("nop6/HI", HI, 32'h12345678);
        chk("nop6/LO", LO, 32'd0);
        chk("nop6/busy", {31'd0, Busy}, 32'd0);

        push(32'hFFFFFFFF, 32'hFFFFFFFA);
        issue(3'd0, 32'hFFFFFFFE, 32'h3);
        finish_long("mult", 5, 0, 1'b0);

        push(32'h2, 32'hFFFFFFFA);
        issue(3'd1, 32'hFFFFFFFE, 32'h3);
        finish_long("multu", 5, 0, 1'b0);

        push(32'hFFFFFFFF, 32'hFFFFFFFD);
        issue(3'd2, 32'hFFFFFFF9, 32'h2);
        finish_long("div_neg", 10, 0, 1'b0);

        push(32'h1, 32'h3);
        issue(3'd3, 32'h7, 32'h2);
        finish_long("divu", 10, 0, 1'b0);

        push(32'h0, 32'h80000000);
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        finish_long("div_ovf", 10, 0, 1'b0);

        issue(3'd4, 32'hAA, 32'd0);
        issue(3'd5, 32'hBB, 32'd0);
        chk("preload/HI", HI, 32'hAA);
        chk("preload/LO", LO, 32'hBB);
        push(32'hAA, 32'hBB);
        issue(3'd3, 32'h5, 32'h0);
        finish_long("divu_zero", 10, 0, 1'b0);

        push(32'h2, 32'hE);
        issue(3'd2, 32'd100, 32'd7);
        finish_long("div_inj", 10, 3, 1'b0);

        push(32'h1, 32'h2);
        issue(3'd2, 32'd9, 32'd4);
        finish_long("div_hold", 10, 0, 1'b1);
        push(32'h0, 32'hC);
        @(negedge clk);
        Start = 1'b0;
        chk("held/accepted", {31'd0, Busy}, 32'd1);
        finish_long("held", 5, 0, 1'b0);

        push(32'h0, 32'd30);
        issue(3'd0, 32'd5, 32'd6);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        void'(sb.pop_back());
        chk("rst_mid/busy", {31'd0, Busy}, 32'd0);
        chk("rst_mid/HI", HI, 32'd0);
        chk("rst_mid/LO", LO, 32'd0);
        repeat (8) @(negedge clk);
        chk("rst_late/busy", {31'd0, Busy}, 32'd0);
        chk("rst_late/HI", HI, 32'd0);
        chk("rst_late/LO", LO, 32'd0);
        chk("sb_final", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
